// File: rtl/stream_mux_rr_sel_pkg.sv
// Shared types and index helpers for the round-robin stream-mux select arbiter.
package stream_mux_rr_sel_pkg;

    // Next-state decision taken on each clock edge, listed in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD,     // nothing changes
        ACT_FLUSH,    // drop lock and burst count, keep pointer
        ACT_ROTATE,   // last beat of a burst transferred, move past the winner
        ACT_BURST,    // beat transferred, burst stays open on the same input
        ACT_STALL,    // beat offered but not accepted, freeze the selection
        ACT_RELEASE,  // stalled beat withdrawn (protocol violation), release in place
        ACT_SKIP      // burst source went idle between beats, release and advance
    } act_e;

    // (a + b) mod n, valid as long as a < n and b < n.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

    // (idx + 1) mod n, valid as long as idx < n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return wrap_add(idx, 1, n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_sel_if.sv
// Handshake view shared between the arbiter and the stream multiplexer it steers.
interface stream_mux_rr_sel_if #(
    parameter int N_INP = 3
);
    import stream_mux_rr_sel_pkg::*;

    localparam int LOG_N_INP = $clog2(N_INP);

    logic [N_INP-1:0]     inp_valid;  // valid of each input stream
    logic                 oup_ready;  // ready of the mux output's consumer
    logic [LOG_N_INP-1:0] sel;        // select index driven into the mux
    logic [N_INP-1:0]     gnt;        // one-hot select masked by ready (mux inp_ready)
    logic                 locked;     // selection frozen by a stall or an open burst

    // The arbiter drives the select side.
    modport master (
        input  inp_valid,
        input  oup_ready,
        output sel,
        output gnt,
        output locked
    );

    // The stream side observes the select and drives the handshake.
    modport slave (
        output inp_valid,
        output oup_ready,
        input  sel,
        input  gnt,
        input  locked
    );

endinterface

// File: rtl/stream_mux_rr_sel_lzc.sv
// Trailing-zero counter: index of the lowest set bit of req, empty when req is all zero.
module stream_mux_rr_sel_lzc
    import stream_mux_rr_sel_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [CNT_W-1:0] tz_cnt,
    output logic             empty
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        tz_cnt = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                tz_cnt = CNT_W'(i);
            end
        end
        empty = ~|req;
    end

endmodule

// File: rtl/stream_mux_rr_sel.sv
// Round-robin select arbiter for a valid-ready stream multiplexer. Selection is
// combinational while unlocked and frozen on ptr_reg while a beat is stalled or a
// burst of up to BURST_LEN beats is open on one input.
module stream_mux_rr_sel
    import stream_mux_rr_sel_pkg::*;
#(
    parameter  int N_INP     = 3,
    parameter  int BURST_LEN = 1,
    localparam int LOG_N_INP = $clog2(N_INP)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    stream_mux_rr_sel_if.master bus
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef logic [LOG_N_INP-1:0] idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(BURST_LEN - 1);

    if (N_INP < 2) begin : g_bad_n_inp
        $error("stream_mux_rr_sel: N_INP must be >= 2");
    end
    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("stream_mux_rr_sel: BURST_LEN must be >= 1");
    end

    idx_t       ptr_reg, ptr_next;
    logic       lock_reg, lock_next;
    cnt_t       cnt_reg, cnt_next;
    act_e       act;

    logic [N_INP-1:0] req_rot;
    idx_t             tz_cnt;
    logic             req_empty;
    idx_t             sel;
    logic             valid_sel;
    logic             hs;

    // Request vector rotated right by the pointer: bit gi is input (ptr + gi) mod N_INP,
    // so only in-range inputs ever take part in the search.
    for (genvar gi = 0; gi < N_INP; gi++) begin : g_rot
        assign req_rot[gi] = bus.inp_valid[idx_t'(wrap_add(32'(ptr_reg), 32'(gi), N_INP))];
    end

    stream_mux_rr_sel_lzc #(
        .WIDTH (N_INP),
        .CNT_W (LOG_N_INP)
    ) u_lzc (
        .req    (req_rot),
        .tz_cnt (tz_cnt),
        .empty  (req_empty)
    );

    // Unlocked: first valid at or after the pointer; locked or idle: the pointer itself.
    always_comb begin
        sel = ptr_reg;
        if (!lock_reg && !req_empty) begin
            sel = idx_t'(wrap_add(32'(ptr_reg), 32'(tz_cnt), N_INP));
        end
    end

    assign valid_sel  = bus.inp_valid[sel];
    assign hs         = valid_sel & bus.oup_ready;
    assign bus.sel    = sel;
    assign bus.locked = lock_reg;

    for (genvar gi = 0; gi < N_INP; gi++) begin : g_gnt
        assign bus.gnt[gi] = (sel == idx_t'(gi)) & bus.oup_ready;
    end

    // Choose the next-state action in priority order and derive the register updates.
    always_comb begin
        act = ACT_HOLD;
        if (flush_i) begin
            act = ACT_FLUSH;
        end else if (hs && (cnt_reg == CNT_LAST)) begin
            act = ACT_ROTATE;
        end else if (hs) begin
            act = ACT_BURST;
        end else if (valid_sel && !bus.oup_ready) begin
            act = ACT_STALL;
        end else if (lock_reg && !valid_sel) begin
            act = (cnt_reg == '0) ? ACT_RELEASE : ACT_SKIP;
        end

        ptr_next  = ptr_reg;
        lock_next = lock_reg;
        cnt_next  = cnt_reg;
        case (act)
            ACT_FLUSH: begin
                lock_next = 1'b0;
                cnt_next  = '0;
            end
            ACT_ROTATE: begin
                ptr_next  = idx_t'(wrap_inc(32'(sel), N_INP));
                lock_next = 1'b0;
                cnt_next  = '0;
            end
            ACT_BURST: begin
                ptr_next  = sel;
                lock_next = 1'b1;
                cnt_next  = cnt_reg + cnt_t'(1);
            end
            ACT_STALL: begin
                ptr_next  = sel;
                lock_next = 1'b1;
            end
            ACT_RELEASE: begin
                lock_next = 1'b0;
                cnt_next  = '0;
            end
            ACT_SKIP: begin
                ptr_next  = idx_t'(wrap_inc(32'(ptr_reg), N_INP));
                lock_next = 1'b0;
                cnt_next  = '0;
            end
            default: begin
            end
        endcase
    end

    // Arbiter state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_reg  <= '0;
            lock_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            ptr_reg  <= ptr_next;
            lock_reg <= lock_next;
            cnt_reg  <= cnt_next;
        end
    end

`ifndef SYNTHESIS
    logic stall_hold_reg;
    idx_t sel_hold_reg;

    // Simulation checks: grant shape, select range, withdrawn stalls, stall stability.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(bus.gnt))
                else $error("stream_mux_rr_sel: gnt not one-hot");
            assert (int'(sel) < N_INP)
                else $error("stream_mux_rr_sel: sel out of range");
            assert (act != ACT_RELEASE)
                else $error("stream_mux_rr_sel: stalled beat withdrawn");
            if (stall_hold_reg) begin
                assert (sel == sel_hold_reg)
                    else $error("stream_mux_rr_sel: sel changed during stall");
            end
        end
        stall_hold_reg <= rst_ni && valid_sel && !bus.oup_ready && !flush_i;
        sel_hold_reg   <= sel;
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr_sel.sv
// Directed bench for stream_mux_rr_sel: four instances cover pure round-robin,
// bursts, non-power-of-two wrap and flush. Stimulus pushes expected outputs into a
// queue; a monitor on the falling edge pops and compares them.
module tb_stream_mux_rr_sel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
    logic flush_a = 1'b0, flush_b = 1'b0, flush_c = 1'b0, flush_d = 1'b0;

    stream_mux_rr_sel_if #(.N_INP(3)) if_a ();
    stream_mux_rr_sel_if #(.N_INP(4)) if_b ();
    stream_mux_rr_sel_if #(.N_INP(5)) if_c ();
    stream_mux_rr_sel_if #(.N_INP(3)) if_d ();

    stream_mux_rr_sel #(.N_INP(3), .BURST_LEN(1)) dut_a (
        .clk_i (clk), .rst_ni (rst_a), .flush_i (flush_a), .bus (if_a));
    stream_mux_rr_sel #(.N_INP(4), .BURST_LEN(3)) dut_b (
        .clk_i (clk), .rst_ni (rst_b), .flush_i (flush_b), .bus (if_b));
    stream_mux_rr_sel #(.N_INP(5), .BURST_LEN(1)) dut_c (
        .clk_i (clk), .rst_ni (rst_c), .flush_i (flush_c), .bus (if_c));
    stream_mux_rr_sel #(.N_INP(3), .BURST_LEN(4)) dut_d (
        .clk_i (clk), .rst_ni (rst_d), .flush_i (flush_d), .bus (if_d));

    typedef struct {
        int         d;
        int         sel;
        logic [7:0] gnt;
        logic       lock;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        if_a.inp_valid = '0; if_a.oup_ready = 1'b0;
        if_b.inp_valid = '0; if_b.oup_ready = 1'b0;
        if_c.inp_valid = '0; if_c.oup_ready = 1'b0;
        if_d.inp_valid = '0; if_d.oup_ready = 1'b0;
    end

    // Monitor: every cycle, compare all expectations issued for this cycle.
    initial begin
        exp_t       e;
        int         a_sel;
        logic [7:0] a_gnt;
        logic       a_lock;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.d)
                    0: begin a_sel = int'(if_a.sel); a_gnt = 8'(if_a.gnt); a_lock = if_a.locked; end
                    1: begin a_sel = int'(if_b.sel); a_gnt = 8'(if_b.gnt); a_lock = if_b.locked; end
                    2: begin a_sel = int'(if_c.sel); a_gnt = 8'(if_c.gnt); a_lock = if_c.locked; end
                    default: begin a_sel = int'(if_d.sel); a_gnt = 8'(if_d.gnt); a_lock = if_d.locked; end
                endcase
                checks++;
                if (a_sel != e.sel || a_gnt !== e.gnt || a_lock !== e.lock) begin
                    errors++;
                    $display("FAIL dut%0d t=%0t: got sel=%0d gnt=%b locked=%b, need sel=%0d gnt=%b locked=%b",
                             e.d, $time, a_sel, a_gnt, a_lock, e.sel, e.gnt, e.lock);
                end else begin
                    $display("dut%0d t=%0t: sel=%0d gnt=%b locked=%b ok",
                             e.d, $time, a_sel, a_gnt, a_lock);
                end
            end
        end
    end

    // One clock cycle of stimulus on one instance, optionally queuing its expected outputs.
    task automatic step(input int d, input logic [7:0] v, input logic r, input logic f,
                        input logic rn, input bit chk, input int es, input logic [7:0] eg,
                        input logic el);
        exp_t e;
        @(posedge clk);
        #1;
        case (d)
            0: begin if_a.inp_valid = v[2:0]; if_a.oup_ready = r; flush_a = f; rst_a = rn; end
            1: begin if_b.inp_valid = v[3:0]; if_b.oup_ready = r; flush_b = f; rst_b = rn; end
            2: begin if_c.inp_valid = v[4:0]; if_c.oup_ready = r; flush_c = f; rst_c = rn; end
            default: begin if_d.inp_valid = v[2:0]; if_d.oup_ready = r; flush_d = f; rst_d = rn; end
        endcase
        if (chk) begin
            e = '{d, es, eg, el};
            q.push_back(e);
        end
    endtask

    task automatic row(input int d, input logic [7:0] v, input logic r, input logic f,
                       input int es, input logic [7:0] eg, input logic el);
        step(d, v, r, f, 1'b1, 1'b1, es, eg, el);
    endtask

    task automatic park(input int d);
        step(d, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);

        // N_INP=3, BURST_LEN=1: reset/idle, zero-latency select, round-robin
        row(0, 8'b000, 1'b0, 1'b0, 0, 8'b000, 1'b0);
        row(0, 8'b100, 1'b1, 1'b0, 2, 8'b100, 1'b0);
        row(0, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b0);
        row(0, 8'b111, 1'b1, 1'b0, 1, 8'b010, 1'b0);
        row(0, 8'b111, 1'b1, 1'b0, 2, 8'b100, 1'b0);
        row(0, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b0);
        row(0, 8'b111, 1'b1, 1'b0, 1, 8'b010, 1'b0);
        row(0, 8'b111, 1'b1, 1'b0, 2, 8'b100, 1'b0);
        // stall lock on input 0, valid[2] raised mid-stall, then release
        row(0, 8'b011, 1'b0, 1'b0, 0, 8'b000, 1'b0);
        row(0, 8'b011, 1'b0, 1'b0, 0, 8'b000, 1'b1);
        row(0, 8'b111, 1'b0, 1'b0, 0, 8'b000, 1'b1);
        row(0, 8'b111, 1'b0, 1'b0, 0, 8'b000, 1'b1);
        row(0, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b1);
        row(0, 8'b011, 1'b1, 1'b0, 1, 8'b010, 1'b0);
        // reset in the middle of a stall on input 2
        row(0, 8'b100, 1'b0, 1'b0, 2, 8'b000, 1'b0);
        step(0, 8'b100, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'b000, 1'b1);
        row(0, 8'b011, 1'b0, 1'b0, 0, 8'b000, 1'b0);
        row(0, 8'b011, 1'b1, 1'b0, 0, 8'b001, 1'b1);
        park(0);

        // N_INP=4, BURST_LEN=3: bursts of three, then an early drop of input 1
        row(1, 8'b1111, 1'b1, 1'b0, 0, 8'b0001, 1'b0);
        row(1, 8'b1111, 1'b1, 1'b0, 0, 8'b0001, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 0, 8'b0001, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 1, 8'b0010, 1'b0);
        row(1, 8'b1111, 1'b1, 1'b0, 1, 8'b0010, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 1, 8'b0010, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 2, 8'b0100, 1'b0);
        row(1, 8'b1111, 1'b1, 1'b0, 2, 8'b0100, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 2, 8'b0100, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 3, 8'b1000, 1'b0);
        row(1, 8'b1111, 1'b1, 1'b0, 3, 8'b1000, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 3, 8'b1000, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 0, 8'b0001, 1'b0);
        row(1, 8'b1111, 1'b1, 1'b0, 0, 8'b0001, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 0, 8'b0001, 1'b1);
        row(1, 8'b1111, 1'b1, 1'b0, 1, 8'b0010, 1'b0);
        row(1, 8'b1101, 1'b1, 1'b0, 1, 8'b0010, 1'b1);
        row(1, 8'b1101, 1'b1, 1'b0, 2, 8'b0100, 1'b0);
        park(1);

        // N_INP=5, BURST_LEN=1: wrap from pointer 4 and idle hold
        row(2, 8'b01000, 1'b1, 1'b0, 3, 8'b01000, 1'b0);
        row(2, 8'b00011, 1'b1, 1'b0, 0, 8'b00001, 1'b0);
        row(2, 8'b00011, 1'b1, 1'b0, 1, 8'b00010, 1'b0);
        row(2, 8'b00011, 1'b1, 1'b0, 0, 8'b00001, 1'b0);
        row(2, 8'b00000, 1'b0, 1'b0, 1, 8'b00000, 1'b0);
        row(2, 8'b10000, 1'b1, 1'b0, 4, 8'b10000, 1'b0);
        row(2, 8'b00000, 1'b0, 1'b0, 0, 8'b00000, 1'b0);
        park(2);

        // N_INP=3, BURST_LEN=4: flush at cnt=2, then a full four-beat burst
        row(3, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b0);
        row(3, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b1);
        row(3, 8'b111, 1'b1, 1'b1, 0, 8'b001, 1'b1);
        row(3, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b0);
        row(3, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b1);
        row(3, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b1);
        row(3, 8'b111, 1'b1, 1'b0, 0, 8'b001, 1'b1);
        row(3, 8'b111, 1'b1, 1'b0, 1, 8'b010, 1'b0);
        park(3);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
